// File: rtl/psx_bus_sniffer.sv
// Passive PlayStation controller bus decoder: shifts cmd/dat bytes on psx_clk rises, frames packets by ATT.
// Optional build macro PSX_SNIFFER_DEGLITCH_EN adds a two-sample filter on psx_clk before edge detection.
module psx_bus_sniffer #(
  parameter int INDEX_WIDTH    = 4,
  parameter int TIMEOUT_WIDTH  = 16,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   psx_att_sync,
  input  logic                   psx_clk_sync,
  input  logic                   psx_cmd_sync,
  input  logic                   psx_dat_sync,
  output logic [7:0]             cmd_byte,
  output logic [7:0]             dat_byte,
  output logic                   byte_strobe,
  output logic [INDEX_WIDTH-1:0] byte_index,
  output logic                   packet_start,
  output logic                   packet_end,
  output logic                   frame_error,
  output logic [1:0]             fsm_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    ABORT  = 2'd2
  } state_t;

  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [INDEX_WIDTH-1:0]   INDEX_MAX    = '1;

  state_t                   state_q, state_d;
  logic [2:0]               bit_count_q, bit_count_d;
  logic [7:0]               cmd_sr_q, cmd_sr_d;
  logic [7:0]               dat_sr_q, dat_sr_d;
  logic [INDEX_WIDTH-1:0]   idx_q, idx_d;
  logic [TIMEOUT_WIDTH-1:0] timer_q, timer_d;
  logic [7:0]               cmd_byte_d, dat_byte_d;
  logic [INDEX_WIDTH-1:0]   byte_index_d;
  logic                     strobe_d, start_d, end_d, ferr_d;
  logic                     clk_prev;
  logic                     rise;

`ifdef PSX_SNIFFER_DEGLITCH_EN
  // clk_prev holds the accepted level; a change needs two matching raw samples.
  logic clk_raw_d;
  logic accept;

  assign accept = (psx_clk_sync != clk_prev) && (clk_raw_d == psx_clk_sync);
  assign rise   = accept & psx_clk_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_prev  <= 1'b1;
      clk_raw_d <= 1'b1;
    end else begin
      clk_raw_d <= psx_clk_sync;
      if (accept) clk_prev <= psx_clk_sync;
    end
  end
`else
  assign rise = psx_clk_sync & ~clk_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) clk_prev <= 1'b1;
    else       clk_prev <= psx_clk_sync;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      bit_count_q  <= '0;
      cmd_sr_q     <= '0;
      dat_sr_q     <= '0;
      idx_q        <= '0;
      timer_q      <= '0;
      cmd_byte     <= '0;
      dat_byte     <= '0;
      byte_index   <= '0;
      byte_strobe  <= 1'b0;
      packet_start <= 1'b0;
      packet_end   <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_count_q  <= bit_count_d;
      cmd_sr_q     <= cmd_sr_d;
      dat_sr_q     <= dat_sr_d;
      idx_q        <= idx_d;
      timer_q      <= timer_d;
      cmd_byte     <= cmd_byte_d;
      dat_byte     <= dat_byte_d;
      byte_index   <= byte_index_d;
      byte_strobe  <= strobe_d;
      packet_start <= start_d;
      packet_end   <= end_d;
      frame_error  <= ferr_d;
    end
  end

  // Priority inside ACTIVE: ATT release, then a counted rise, then the timeout.
  always_comb begin
    state_d      = state_q;
    bit_count_d  = bit_count_q;
    cmd_sr_d     = cmd_sr_q;
    dat_sr_d     = dat_sr_q;
    idx_d        = idx_q;
    timer_d      = timer_q;
    cmd_byte_d   = cmd_byte;
    dat_byte_d   = dat_byte;
    byte_index_d = byte_index;
    strobe_d     = 1'b0;
    start_d      = 1'b0;
    end_d        = 1'b0;
    ferr_d       = 1'b0;
    case (state_q)
      IDLE: begin
        bit_count_d = '0;
        timer_d     = '0;
        if (!psx_att_sync) begin
          state_d = ACTIVE;
          start_d = 1'b1;
          idx_d   = '0;
        end
      end
      ACTIVE: begin
        if (psx_att_sync) begin
          state_d     = IDLE;
          end_d       = 1'b1;
          ferr_d      = (bit_count_q != 3'd0);
          bit_count_d = '0;
          timer_d     = '0;
        end else if (rise) begin
          timer_d     = '0;
          cmd_sr_d    = {psx_cmd_sync, cmd_sr_q[7:1]};
          dat_sr_d    = {psx_dat_sync, dat_sr_q[7:1]};
          bit_count_d = bit_count_q + 3'd1;
          if (bit_count_q == 3'd7) begin
            cmd_byte_d   = cmd_sr_d;
            dat_byte_d   = dat_sr_d;
            strobe_d     = 1'b1;
            byte_index_d = idx_q;
            if (idx_q != INDEX_MAX) idx_d = idx_q + INDEX_WIDTH'(1);
          end
        end else if (bit_count_q == 3'd0) begin
          timer_d = '0;
        end else if (timer_q == TIMEOUT_LAST) begin
          ferr_d      = 1'b1;
          bit_count_d = '0;
          timer_d     = '0;
          state_d     = ABORT;
        end else begin
          timer_d = timer_q + TIMEOUT_WIDTH'(1);
        end
      end
      ABORT: begin
        if (psx_att_sync) begin
          state_d = IDLE;
          end_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fsm_state = state_q;

endmodule

// File: tb/tb_psx_bus_sniffer.sv
// Directed bench for psx_bus_sniffer: bit-bangs bus packets and scores strobed bytes and framing pulses.
// Expectations follow PSX_SNIFFER_DEGLITCH_EN when the bench is built with it.
module tb_psx_bus_sniffer;
  localparam int IW = 4;
  localparam int W  = IW + 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          psx_att_sync, psx_clk_sync, psx_cmd_sync, psx_dat_sync;
  logic [7:0]    cmd_byte, dat_byte;
  logic          byte_strobe, packet_start, packet_end, frame_error;
  logic [IW-1:0] byte_index;
  logic [1:0]    fsm_state;

  int checks = 0;
  int failures = 0;
  int n_start = 0, n_end = 0, n_ferr = 0, n_end_ferr = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];

  psx_bus_sniffer #(.INDEX_WIDTH(IW), .TIMEOUT_WIDTH(16), .TIMEOUT_CYCLES(1000)) dut (
    .clk(clk), .reset(reset),
    .psx_att_sync(psx_att_sync), .psx_clk_sync(psx_clk_sync),
    .psx_cmd_sync(psx_cmd_sync), .psx_dat_sync(psx_dat_sync),
    .cmd_byte(cmd_byte), .dat_byte(dat_byte), .byte_strobe(byte_strobe),
    .byte_index(byte_index), .packet_start(packet_start), .packet_end(packet_end),
    .frame_error(frame_error), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // monitor on the inactive edge
  always @(negedge clk) begin
    if (byte_strobe) obs_q.push_back({byte_index, cmd_byte, dat_byte});
    if (packet_start) n_start++;
    if (packet_end) n_end++;
    if (frame_error) n_ferr++;
    if (packet_end && frame_error) n_end_ferr++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks: inputs change 1ns after the rising edge
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic c, input logic d);
    psx_clk_sync = 1'b0;
    psx_cmd_sync = c;
    psx_dat_sync = d;
    cycles(3);
    psx_clk_sync = 1'b1;
    cycles(3);
  endtask

  task automatic send_byte(input logic [7:0] c, input logic [7:0] d);
    for (int i = 0; i < 8; i++) send_bit(c[i], d[i]);
  endtask

  task automatic att_low();
    psx_att_sync = 1'b0;
    cycles(4);
  endtask

  task automatic att_high();
    psx_att_sync = 1'b1;
    cycles(4);
  endtask

  task automatic expect_byte(input logic [IW-1:0] idx, input logic [7:0] c, input logic [7:0] d);
    exp_q.push_back({idx, c, d});
  endtask

  // scoreboard: compare observed strobes against the expected queue
  task automatic score(input string tag);
    logic [W-1:0] e, o;
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check({tag, "_byte"}, o, e);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin : main
    int s_start, s_end, s_ferr, s_ef, waited;
    logic [7:0] pc[5];
    logic [7:0] pd[5];
    pc = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00};
    pd = '{8'hFF, 8'h41, 8'h5A, 8'hFF, 8'hFF};

    reset = 1'b1;
    psx_att_sync = 1'b1;
    psx_clk_sync = 1'b1;
    psx_cmd_sync = 1'b0;
    psx_dat_sync = 1'b0;
    cycles(3);
    check("rst_outputs", {cmd_byte, dat_byte, byte_strobe, byte_index, packet_start, packet_end, frame_error},
          '0);
    check("rst_state", fsm_state, 2'd0);
    reset = 1'b0;
    cycles(2);

    // single byte packet
    s_start = n_start; s_end = n_end; s_ferr = n_ferr;
    att_low();
    check("p1_state_active", fsm_state, 2'd1);
    send_byte(8'h01, 8'hFF);
    expect_byte(4'd0, 8'h01, 8'hFF);
    att_high();
    check("p1_start", n_start - s_start, 1);
    check("p1_end", n_end - s_end, 1);
    check("p1_ferr", n_ferr - s_ferr, 0);
    check("p1_hold_cmd", cmd_byte, 8'h01);
    check("p1_hold_dat", dat_byte, 8'hFF);
    score("p1");

    // five byte poll packet
    s_ferr = n_ferr;
    att_low();
    for (int i = 0; i < 5; i++) begin
      send_byte(pc[i], pd[i]);
      expect_byte(IW'(i), pc[i], pd[i]);
    end
    att_high();
    check("p5_ferr", n_ferr - s_ferr, 0);
    score("p5");

    // ATT rises after 3 bits
    s_end = n_end; s_ferr = n_ferr; s_ef = n_end_ferr;
    att_low();
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b1);
    att_high();
    check("part_end", n_end - s_end, 1);
    check("part_ferr", n_ferr - s_ferr, 1);
    check("part_same_cycle", n_end_ferr - s_ef, 1);
    score("part");
    att_low();
    send_byte(8'h42, 8'h41);
    expect_byte(4'd0, 8'h42, 8'h41);
    att_high();
    score("after_part");

    // index saturation over 17 bytes
    att_low();
    for (int i = 0; i < 17; i++) begin
      send_byte(8'(i * 13 + 7), ~8'(i * 13 + 7));
      expect_byte((i > 15) ? 4'd15 : IW'(i), 8'(i * 13 + 7), ~8'(i * 13 + 7));
    end
    att_high();
    score("sat");

    // timeout mid-byte
    s_end = n_end; s_ferr = n_ferr;
    att_low();
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    waited = 0;
    while (n_ferr == s_ferr && waited < 1100) begin
      cycles(1);
      waited++;
    end
    check("to_ferr_seen", n_ferr - s_ferr, 1);
    check("to_latency_ok", (waited >= 990 && waited <= 1010), 1);
    check("to_state_abort", fsm_state, 2'd2);
    send_byte(8'hAA, 8'h55);
    cycles(20);
    check("to_ferr_once", n_ferr - s_ferr, 1);
    check("to_no_end_yet", n_end - s_end, 0);
    att_high();
    check("to_end", n_end - s_end, 1);
    check("to_idle", fsm_state, 2'd0);
    score("to");

    // single-cycle low blip on psx_clk mid-byte
    s_ferr = n_ferr;
    att_low();
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    psx_clk_sync = 1'b0;
    psx_cmd_sync = 1'b0;
    psx_dat_sync = 1'b1;
    cycles(1);
    psx_clk_sync = 1'b1;
    cycles(3);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    att_high();
`ifdef PSX_SNIFFER_DEGLITCH_EN
    expect_byte(4'd0, 8'hFF, 8'h00);
    check("blip_ferr", n_ferr - s_ferr, 0);
`else
    expect_byte(4'd0, 8'hEF, 8'h10);
    check("blip_ferr", n_ferr - s_ferr, 1);
`endif
    score("blip");

    // reset mid-byte
    s_start = n_start; s_end = n_end; s_ferr = n_ferr;
    att_low();
    for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b1);
    reset = 1'b1;
    cycles(2);
    check("mrst_outputs", {cmd_byte, dat_byte, byte_strobe, byte_index, packet_start, packet_end, frame_error},
          '0);
    check("mrst_state", fsm_state, 2'd0);
    reset = 1'b0;
    cycles(5);
    check("mrst_no_end", n_end - s_end, 0);
    check("mrst_no_ferr", n_ferr - s_ferr, 0);
    check("mrst_restart", n_start - s_start, 2);
    send_byte(8'h5A, 8'hA5);
    expect_byte(4'd0, 8'h5A, 8'hA5);
    att_high();
    check("mrst_clean_ferr", n_ferr - s_ferr, 0);
    score("mrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
